// File: rtl/down_count_monitor.sv
// Samples an asynchronous ripple down counter, filters glitches and tracks legal
// down-steps, 0->max wraps (saturating count) and illegal jumps.
module down_count_monitor #(
    parameter int WIDTH         = 4,
    parameter int WRAP_CNT_W    = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic                  enable,
    input  logic                  clear,
    output logic                  cnt_valid,
    output logic [WIDTH-1:0]      cnt_out,
    output logic                  step_pulse,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  wrap_sat,
    output logic                  step_err,
    output logic                  zero_flag
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    state_t state, state_n;

    logic [WIDTH-1:0]      s1, s2;
    logic [RUN_W-1:0]      run;
    logic                  accept;
    logic [WIDTH-1:0]      dec;

    logic                  cnt_valid_n;
    logic [WIDTH-1:0]      cnt_out_n;
    logic                  step_n, wrap_n;
    logic [WRAP_CNT_W-1:0] wcnt_n;
    logic                  wsat_n, err_n;

    // run = number of consecutive clock samples s2 has held its current value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1  <= '0;
            s2  <= '0;
            run <= '0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            if (s1 != s2)
                run <= RUN_W'(1);
            else if (run != RUN_MAX)
                run <= run + RUN_W'(1);
        end
    end

    assign accept = (run == RUN_MAX);
    assign dec    = cnt_out - WIDTH'(1);

    always_comb begin
        state_n     = state;
        cnt_valid_n = cnt_valid;
        cnt_out_n   = cnt_out;
        step_n      = 1'b0;
        wrap_n      = 1'b0;
        // clear takes effect first so a coincident event lands on the cleared value
        wcnt_n      = clear ? '0   : wrap_count;
        wsat_n      = clear ? 1'b0 : wrap_sat;
        err_n       = clear ? 1'b0 : step_err;

        if (!enable) begin
            state_n     = IDLE;
            cnt_valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: state_n = ACQUIRE;
                ACQUIRE: begin
                    if (accept) begin
                        cnt_out_n   = s2;
                        cnt_valid_n = 1'b1;
                        state_n     = TRACK;
                    end
                end
                TRACK: begin
                    if (accept && (s2 != cnt_out)) begin
                        cnt_out_n = s2;
                        if (s2 == dec) begin
                            step_n = 1'b1;
                            if (cnt_out == '0) begin
                                wrap_n = 1'b1;
                                if (&wcnt_n)
                                    wsat_n = 1'b1;
                                else
                                    wcnt_n = wcnt_n + WRAP_CNT_W'(1);
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt_valid  <= 1'b0;
            cnt_out    <= '0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            wrap_sat   <= 1'b0;
            step_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt_valid  <= cnt_valid_n;
            cnt_out    <= cnt_out_n;
            step_pulse <= step_n;
            wrap_pulse <= wrap_n;
            wrap_count <= wcnt_n;
            wrap_sat   <= wsat_n;
            step_err   <= err_n;
        end
    end

    assign zero_flag = cnt_valid && (cnt_out == '0);

endmodule
